// File: rtl/rv_core_pkg.sv
// Shared definitions for the 3-stage RV32I core: NOP encoding, reset vector
// and the IF/ID pipeline register layout consumed by the decode stage.
package rv_core_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program-counter register and next-pc selection (+4 / hold / redirect target).
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_pc_gen
    import rv_core_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              bubble,
    output logic              misalign_err
);

    logic [ADDR_W-1:0] pc_p0;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] target;
    logic              misaligned;
    logic              halted;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic err_p0;

    assign misaligned   = redirect & (redirect_pc[1:0] != 2'b00);
    assign halted       = err_p0;
    assign misalign_err = err_p0;
    assign target       = redirect_pc;

    // Sticky: once set, only reset clears it and fetch stays halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_p0 <= 1'b0;
        else if (misaligned)
            err_p0 <= 1'b1;
    end
`else
    assign misaligned   = 1'b0;
    assign halted       = 1'b0;
    assign misalign_err = 1'b0;
    assign target       = redirect_pc & ~ADDR_W'(3);
`endif

    always_comb begin
        pc_nxt = pc_p0;
        if (halted) begin
            pc_nxt = pc_p0;
        end else if (redirect) begin
            if (!misaligned)
                pc_nxt = target;
        end else if (!stall) begin
            pc_nxt = pc_p0 + ADDR_W'(4);
        end
    end

    // Stage 0: fetch address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_p0 <= RESET_PC;
        else
            pc_p0 <= pc_nxt;
    end

    assign pc     = pc_p0;
    assign bubble = redirect | halted;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the instruction-memory word index and
// registers the returned word into IF/ID. Option: FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import rv_core_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_id_valid,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               misalign_err
);

    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

    logic [ADDR_W-1:0]  pc_p0;
    logic               bubble;
    logic               vld_p1;
    logic [ADDR_W-1:0]  pc_p1;
    logic [INSTR_W-1:0] instr_p1;

    fetch_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .pc           (pc_p0),
        .bubble       (bubble),
        .misalign_err (misalign_err)
    );

    assign imem_addr = {2'b00, pc_p0[ADDR_W-1:2]};

    // Stage 1: IF/ID register; bubbles always carry a NOP so decode needs no gating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            pc_p1    <= '0;
            instr_p1 <= NOP;
        end else if (bubble) begin
            vld_p1   <= 1'b0;
            pc_p1    <= '0;
            instr_p1 <= NOP;
        end else if (!stall) begin
            vld_p1   <= 1'b1;
            pc_p1    <= pc_p0;
            instr_p1 <= imem_instr;
        end
    end

    assign if_id_valid = vld_p1;
    assign if_id_pc    = pc_p1;
    assign if_id_instr = instr_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IF/ID state is queued as each
// cycle's stimulus is driven and compared one clock edge later.
module tb_fetch_unit;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        misalign_err;

    logic [31:0] mem [64];
    exp_t        sb[$];
    exp_t        last_exp;
    logic [31:0] mpc;
    logic        halted;
    int          n_checks = 0;
    int          n_errors = 0;

    fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    // Low 64 words are a small RAM; anything above returns an address-derived pattern.
    always_comb begin
        if (imem_addr[31:6] == 26'd0)
            imem_instr = mem[imem_addr[5:0]];
        else
            imem_instr = imem_addr ^ 32'hFFFF_0000;
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [31:0] idx;
        idx = {2'b00, pc[31:2]};
        if (idx[31:6] == 26'd0)
            return mem[idx[5:0]];
        return idx ^ 32'hFFFF_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        check({tag, "_pc"}, if_id_pc, 32'd0);
        check({tag, "_instr"}, if_id_instr, NOP);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_err"}, {31'd0, misalign_err}, 32'd0);
    endtask

    task automatic model_reset();
        mpc          = 32'h0;
        halted       = 1'b0;
        last_exp.vld   = 1'b0;
        last_exp.pc    = 32'h0;
        last_exp.instr = NOP;
        last_exp.addr  = 32'h0;
        last_exp.err   = 1'b0;
    endtask

    // One clock: drive at negedge, queue the expectation, compare after the edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
        exp_t e;
        exp_t got;
        @(negedge clk);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        e = last_exp;
        if (halted) begin
            e.vld = 1'b0; e.pc = 32'h0; e.instr = NOP;
        end else if (rd) begin
            e.vld = 1'b0; e.pc = 32'h0; e.instr = NOP;
            if (TRAP && rpc[1:0] != 2'b00)
                halted = 1'b1;
            else
                mpc = {rpc[31:2], 2'b00};
        end else if (!st) begin
            e.vld = 1'b1; e.pc = mpc; e.instr = word_at(mpc);
            mpc = mpc + 32'd4;
        end
        e.addr = {2'b00, mpc[31:2]};
        e.err  = halted;
        last_exp = e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        stall    = 1'b0;
        redirect = 1'b0;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check("valid", {31'd0, if_id_valid}, {31'd0, got.vld});
            check("pc",    if_id_pc,    got.pc);
            check("instr", if_id_instr, got.instr);
            check("addr",  imem_addr,   got.addr);
            check("err",   {31'd0, misalign_err}, {31'd0, got.err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 32'hA500_0000 + i;
        model_reset();

        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Sequential fetch, cycles 1..2
        step(1'b0, 1'b0, 32'h0);
        check("first_pc", if_id_pc, 32'h0);
        check("first_instr", if_id_instr, 32'hA500_0000);
        step(1'b0, 1'b0, 32'h0);
        // Stall three cycles, then resume
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        check("stall_hold_pc", if_id_pc, 32'h4);
        check("stall_hold_addr", imem_addr, 32'h2);
        step(1'b0, 1'b0, 32'h0);
        check("resume_pc", if_id_pc, 32'h8);
        step(1'b0, 1'b0, 32'h0);
        // Redirect to 0x40
        step(1'b0, 1'b1, 32'h40);
        step(1'b0, 1'b0, 32'h0);
        check("redir_pc", if_id_pc, 32'h40);
        check("redir_instr", if_id_instr, 32'hA500_0010);
        step(1'b0, 1'b0, 32'h0);
        // Redirect together with stall: redirect wins
        step(1'b1, 1'b1, 32'h20);
        step(1'b0, 1'b0, 32'h0);
        check("redir_stall_pc", if_id_pc, 32'h20);
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        // Wrap-around at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);

        // Asynchronous reset between edges, with a stall pending
        #2;
        stall = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        stall = 1'b0;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);

        // Misaligned target: trap halts fetch, otherwise masked to 0x20
        step(1'b0, 1'b1, 32'h22);
        step(1'b0, 1'b0, 32'h0);
        check("misalign_flag", {31'd0, misalign_err}, {31'd0, TRAP});
        check("misalign_pc", if_id_pc, TRAP ? 32'h0 : 32'h20);
        step(1'b0, 1'b1, 32'h40);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
